if_stage: RTL

- Instruction-fetch stage of the pipelined RV32I core inside top.
- Owns the PC, drives the address of the synchronous-read instruction BRAM (imem, 1-cycle read latency), and produces the IF/ID pipeline register consumed by decode.
- Absorbs the BRAM latency, load-use stalls and EX-stage redirects (branch/jump), inserting NOP bubbles on wrong-path fetches.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/if_pc_gen.sv | 41 ++++
 rtl/if_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core types: XLEN, bubble encoding, IF state and IF/ID bundle.
// Consumed by if_stage, if_pc_gen and id_stage.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_pc_gen.sv
// Next-PC selection plus the fetch_pc/fetch_valid tracking registers.
// fetch_pc names the address whose BRAM data is on the read port now.
module if_pc_gen
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  if_state_t       state,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_valid
);

  always_comb begin
    pc_next = fetch_pc + 32'd4;
    if (state == S_BOOT)
      pc_next = RESET_PC;
    else if (redirect)
      pc_next = redirect_pc;
    else if (stall)
      pc_next = fetch_pc;
  end

  // Wrong-path data in a redirect cycle is squashed in IF/ID itself, so
  // the target's data one cycle later is already on the correct path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
    end else begin
      fetch_pc    <= pc_next;
      fetch_valid <= (state == S_RUN) | (state == S_BOOT);
    end
  end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, imem addressing, IF/ID register.
// Optional perf counters built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic               imem_en_o,
  input  logic [31:0]        imem_rdata_i,
  output logic [31:0]        if_id_pc_o,
  output logic [31:0]        if_id_inst_o,
  output logic               if_id_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        if_fetch_cnt_o,
  output logic [31:0]        if_bubble_cnt_o
`endif
);

  import riscv_pkg::*;

  if_state_t       state;
  if_state_t       state_d;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_valid;
  if_id_t          if_id;
  logic            load;
  logic            load_valid;
  logic            unused_pc_bits;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      state <= S_BOOT;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  if_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .state      (state),
    .stall      (stall_i),
    .redirect   (redirect_i),
    .redirect_pc(redirect_pc_i),
    .pc_next    (pc_next),
    .fetch_pc   (fetch_pc),
    .fetch_valid(fetch_valid)
  );

  assign imem_addr_o    = pc_next[IMEM_AW+1:2];
  assign imem_en_o      = sys_rst_n;
  assign unused_pc_bits = ^{pc_next[XLEN-1:IMEM_AW+2], pc_next[1:0]};

  // Redirect overrides stall: it always flushes IF/ID.
  assign load       = redirect_i | ~stall_i;
  assign load_valid = ~redirect_i & fetch_valid;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      if_id <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
    end else if (load) begin
      if_id.pc    <= fetch_pc;
      if_id.inst  <= load_valid ? imem_rdata_i : NOP_INST;
      if_id.valid <= load_valid;
    end
  end

  assign if_id_pc_o    = if_id.pc;
  assign if_id_inst_o  = if_id.inst;
  assign if_id_valid_o = if_id.valid;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      if_fetch_cnt_o  <= '0;
      if_bubble_cnt_o <= '0;
    end else if (load) begin
      if (load_valid)
        if_fetch_cnt_o <= if_fetch_cnt_o + 32'd1;
      else
        if_bubble_cnt_o <= if_bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule
